// File: rtl/pc_fetch_ctrl.sv
// PC owner and single-outstanding instruction fetch with valid/ready to decode.
// Optional FETCH_PERF_EN adds saturating fetch and stall counters.
module pc_fetch_ctrl #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_next,
  input  logic        stall,
  output logic [15:0] pc_curr,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  input  logic        inst_ready,
`ifdef FETCH_PERF_EN
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_stall_cnt,
`endif
  output logic        halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_VALID,
    S_HALTED
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt;
  logic        r_req, w_req_nxt;
  logic        r_valid, w_valid_nxt;
  logic [15:0] r_inst, w_inst_nxt;
  logic [15:0] r_inst_pc, w_inst_pc_nxt;
  logic        r_halted, w_halted_nxt;
  logic        w_accept;
  logic        w_is_halt;
  logic        w_fetch_ev;
  logic        w_stall_ev;

  assign w_accept   = (r_state == S_VALID) && inst_ready && !stall;
  assign w_is_halt  = (r_inst[15:12] == HALT_OPCODE);
  assign w_fetch_ev = (r_state == S_REQ) && imem_ack;
  assign w_stall_ev = (r_state == S_VALID) && stall;

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_req_nxt     = r_req;
    w_valid_nxt   = r_valid;
    w_inst_nxt    = r_inst;
    w_inst_pc_nxt = r_inst_pc;
    w_halted_nxt  = r_halted;
    unique case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        w_req_nxt   = 1'b1;
      end
      S_REQ: begin
        if (imem_ack) begin
          w_inst_nxt    = imem_rdata;
          w_inst_pc_nxt = r_pc;
          w_valid_nxt   = 1'b1;
          w_req_nxt     = 1'b0;
          w_state_nxt   = S_VALID;
        end
      end
      S_VALID: begin
        if (w_accept) begin
          w_valid_nxt = 1'b0;
          if (w_is_halt) begin
            w_halted_nxt = 1'b1;
            w_state_nxt  = S_HALTED;
          end else begin
            // PC is always halfword aligned
            w_pc_nxt    = {pc_next[15:1], 1'b0};
            w_req_nxt   = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
      end
      S_HALTED: begin
        w_req_nxt    = 1'b0;
        w_valid_nxt  = 1'b0;
        w_halted_nxt = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_req     <= 1'b0;
      r_valid   <= 1'b0;
      r_inst    <= 16'h0000;
      r_inst_pc <= 16'h0000;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_req     <= w_req_nxt;
      r_valid   <= w_valid_nxt;
      r_inst    <= w_inst_nxt;
      r_inst_pc <= w_inst_pc_nxt;
      r_halted  <= w_halted_nxt;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_cnt <= 16'h0000;
      r_stall_cnt <= 16'h0000;
    end else begin
      if (w_fetch_ev && r_fetch_cnt != 16'hFFFF)
        r_fetch_cnt <= r_fetch_cnt + 16'd1;
      if (w_stall_ev && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`else
  logic w_unused_perf;
  assign w_unused_perf = w_fetch_ev ^ w_stall_ev;
`endif

  assign pc_curr    = r_pc;
  assign imem_addr  = r_pc;
  assign imem_req   = r_req;
  assign inst_valid = r_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign halted     = r_halted;

endmodule
